psum_accum_tree: RTL and testbench
==================================

// Module: psum_accum_tree
// PURPOSE
//  Parametrised successor to the fixed-size partial-sum adder: reduces N_OUT windows of up to KMAX
//  signed multiplier products each into N_OUT partial sums. Adds a pipelined tree, ready/valid backpressure,
//  runtime kernel-size masking, multi-round accumulation (first/last) with saturation, and stride-2 compaction.
//  Sits between the multiplier array and the psum buffer of the conv engine.
// PARAMETERS
//  PROD_W  16  signed product width
//  KMAX     9  max products per window (taps)
//  N_OUT    8  output lanes (windows per beat); even
//  PSUM_W  24  psum/accumulator width; must be >= PROD_W+clog2(KMAX)
// PORTS
//  clk        in   1                   clock, all state on rising edge
//  rst        in   1                   asynchronous, active-high reset
//  cfg_ksize  in   clog2(KMAX+1)       active taps per window, sampled with each accepted beat
//  cfg_stride2 in  1                   1: stride-2 output compaction, sampled with beat
//  in_valid   in   1                   beat valid
//  in_ready   out  1                   beat accepted when in_valid&in_ready
//  in_first   in   1                   beat starts a new accumulation (acc discarded)
//  in_last    in   1                   beat ends accumulation; result emitted
//  in_prod    in   N_OUT*KMAX*PROD_W   lane l tap t at [(l*KMAX+t)*PROD_W +: PROD_W], signed
//  out_valid  out  1                   out_psum valid
//  out_ready  in   1                   consumer accepts when out_valid&out_ready
//  out_psum   out  N_OUT*PSUM_W        lane l at [l*PSUM_W +: PSUM_W], signed
//  out_sat    out  N_OUT               per-lane saturation occurred in this accumulation
// BEHAVIOUR
//  - Reset: in_ready=1 after reset, out_valid=0, out_psum=0, out_sat=0, accumulators=0, all stage valids=0.
//  - Global advance adv = !out_valid | out_ready; in_ready = adv. When adv=0 every stage holds (no bubble loss).
//  - Masking: tap t zeroed when t >= cfg_ksize; cfg_ksize=0 -> all-zero sums; cfg_ksize>KMAX clamped to KMAX.
//  - Tree: D=clog2(KMAX) registered levels, pairwise adds, odd element passed through; internal width
//    PROD_W+level, exact (no overflow); result sign-extended to PSUM_W.
//  - first/last/ksize/stride2 travel in the pipeline with their beat.
//  - Accumulate stage (after level D): s = first ? tree : sat(acc+tree). Saturate to
//    [-2^(PSUM_W-1), 2^(PSUM_W-1)-1]; sat flag sticky per lane, cleared by first.
//    last=0: acc<=s. last=1: out_psum<=s (compacted if stride2), out_sat<=flags, out_valid<=1, acc<=0, flags<=0.
//  - Latency: accepted last beat -> out_valid high after D+1 rising edges with no stall (KMAX=9: 5 cycles).
//  - Throughput: one beat/cycle while adv=1; back-to-back single-beat (first&last) windows give one result/cycle.
//  - out_valid falls on out_ready edge unless a new result loads same edge (then stays 1, data replaced).
//  - Stride2: out lane i (i<N_OUT/2) = sum lane 2i; lanes >= N_OUT/2 forced 0, sat 0.
//  - Boundaries: first&last same beat = single-round window; first mid-accumulation discards acc;
//    last with no prior first after reset accumulates onto 0; stall mid-window preserves acc and pipeline;
//    rst mid-operation clears everything asynchronously, in-flight beats lost, no spurious out_valid.
// STRUCTURE
//  - psum_pkg: localparams TREE_D=clog2(KMAX), KSZ_W, function sat_add(a,b,PSUM_W) returning {sat,sum}.
//  - Sub-module psum_tree_lane: one lane's masking + D-level registered tree, enable=adv;
//    instantiated N_OUT times. Top holds sideband pipeline, accumulators, saturation, compaction, output reg.
// TESTING
//  1 Reset: assert rst mid-stream -> out_valid=0, out_psum=0, in_ready=1; next window result unaffected.
//  2 Single round ksize=9, all taps=3, first&last -> every lane 27 after 5 cycles; ksize=4 -> 12; ksize=0 -> 0.
//  3 Three rounds (first,-,last) taps=-2, ksize=9 -> each lane -54, out_valid exactly once, out_sat=0.
//  4 Saturation: taps=32767, ksize=9, 40 rounds -> lane = 8388607 (0x7FFFFF), out_sat=1; next first clears.
//  5 Stride2: lane l taps all l+1, ksize=1 -> out lanes 0..3 = 1,3,5,7; lanes 4..7 = 0.
//  6 Backpressure: back-to-back single-round beats, out_ready toggled 1010.. -> no result dropped/duplicated,
//    in_ready=0 exactly when out_valid&!out_ready, result order matches input order.

Source files
------------

// File: rtl/psum_pkg.sv
// ---------------------------------------------------------------------------
// psum_pkg
//   Shared definitions for the partial-sum accumulation tree.
//   - Default configuration of the block (product width, taps, lanes, psum width).
//   - TREE_D / KSZ_W: tree depth and kernel-size field width for that default.
//   - node_cnt(): number of nodes held at a given tree level.
//   - sat_add(): signed add with saturation to a psum_w-bit range, returns
//     {sat, sum} where sum is the clamped value sign-extended to SAT_IW bits.
// ---------------------------------------------------------------------------
package psum_pkg;

   localparam int PROD_W_DEF = 16;
   localparam int KMAX_DEF   = 9;
   localparam int N_OUT_DEF  = 8;
   localparam int PSUM_W_DEF = 24;

   localparam int TREE_D = $clog2(KMAX_DEF);
   localparam int KSZ_W  = $clog2(KMAX_DEF + 1);

   // Internal width of sat_add; wide enough that adding two sign-extended
   // psum values can never wrap before the clamp is applied.
   localparam int SAT_IW = 64;

   // Nodes at level lvl of a pairwise tree over kmax leaves: ceil(kmax / 2^lvl).
   // Repeated ceil-halving equals a single ceil division by 2^lvl.
   function automatic int node_cnt(input int kmax, input int lvl);
      return (kmax + (1 << lvl) - 1) >> lvl;
   endfunction

   function automatic logic [SAT_IW:0] sat_add(
      input logic signed [SAT_IW-1:0] a,
      input logic signed [SAT_IW-1:0] b,
      input int                       psum_w
   );
      logic signed [SAT_IW-1:0] s;
      logic signed [SAT_IW-1:0] hi;
      logic signed [SAT_IW-1:0] lo;
      logic                     sat;
      s   = a + b;
      hi  = (64'sd1 <<< (psum_w - 1)) - 64'sd1;
      lo  = -hi - 64'sd1;
      sat = 1'b0;
      if (s > hi) begin
         s   = hi;
         sat = 1'b1;
      end else if (s < lo) begin
         s   = lo;
         sat = 1'b1;
      end
      return {sat, s};
   endfunction

endpackage

// File: rtl/psum_tree_lane.sv
// ---------------------------------------------------------------------------
// psum_tree_lane
//   One output lane: masks the KMAX products of a window by the runtime kernel
//   size, then reduces them through TD registered pairwise-add levels.
//   Level k stores ceil(KMAX/2^k) nodes of width PROD_W+k, so every add is
//   exact; an odd leftover node is passed through unchanged.
// Ports
//   clk, rst  clock, asynchronous active-high reset
//   en        pipeline advance; all levels hold when low
//   ksize     active taps; taps t >= ksize are zeroed, values > KMAX clamp
//   prod      KMAX signed products, tap t at [t*PROD_W +: PROD_W]
//   sum       level-TD result sign-extended to PSUM_W
// ---------------------------------------------------------------------------
module psum_tree_lane
   import psum_pkg::*;
#(
   parameter int PROD_W = PROD_W_DEF,
   parameter int KMAX   = KMAX_DEF,
   parameter int PSUM_W = PSUM_W_DEF,
   parameter int TD     = TREE_D,
   parameter int KW     = KSZ_W
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   en,
   input  logic [KW-1:0]          ksize,
   input  logic [KMAX*PROD_W-1:0] prod,
   output logic [PSUM_W-1:0]      sum
);

   logic [KW-1:0]            ksz_eff;
   logic signed [PROD_W-1:0] tap_m [KMAX];

   always_comb begin
      ksz_eff = (ksize > KW'(KMAX)) ? KW'(KMAX) : ksize;
      for (int t = 0; t < KMAX; t++) begin
         tap_m[t] = (KW'(t) < ksz_eff) ? prod[t*PROD_W +: PROD_W] : '0;
      end
   end

   for (genvar lvl = 1; lvl <= TD; lvl++) begin : g_lvl
      localparam int NI = node_cnt(KMAX, lvl - 1);
      localparam int NO = node_cnt(KMAX, lvl);
      localparam int IW = PROD_W + lvl - 1;
      localparam int OW = PROD_W + lvl;

      logic signed [IW-1:0] src   [NI];
      logic signed [OW-1:0] sum_d [NO];
      logic signed [OW-1:0] sum_q [NO];

      if (lvl == 1) begin : g_src_taps
         assign src = tap_m;
      end else begin : g_src_prev
         assign src = g_lvl[lvl-1].sum_q;
      end

      for (genvar j = 0; j < NO; j++) begin : g_node
         if (2 * j + 1 < NI) begin : g_pair
            assign sum_d[j] = OW'(src[2*j]) + OW'(src[2*j+1]);
         end else begin : g_pass
            assign sum_d[j] = OW'(src[2*j]);
         end
      end

      always_ff @(posedge clk or posedge rst) begin
         if (rst) begin
            for (int i = 0; i < NO; i++) begin
               sum_q[i] <= '0;
            end
         end else if (en) begin
            sum_q <= sum_d;
         end
      end
   end

   assign sum = PSUM_W'(g_lvl[TD].sum_q[0]);

endmodule

// File: rtl/psum_accum_tree.sv
// ---------------------------------------------------------------------------
// psum_accum_tree
//   Reduces N_OUT windows of up to KMAX signed products into N_OUT partial
//   sums per beat, accumulates them over multiple rounds (first/last) with
//   per-lane saturation, and optionally compacts lanes for stride-2 output.
// Ports
//   clk, rst              clock, asynchronous active-high reset
//   cfg_ksize             active taps per window, travels with the beat
//   cfg_stride2           1: out lane i = sum lane 2i, upper half forced 0
//   in_valid/in_ready     input beat handshake
//   in_first/in_last      beat starts / ends an accumulation
//   in_prod               lane l tap t at [(l*KMAX+t)*PROD_W +: PROD_W]
//   out_valid/out_ready   result handshake
//   out_psum              lane l at [l*PSUM_W +: PSUM_W], signed
//   out_sat               per-lane saturation seen during the accumulation
//
// Handshake: a transfer happens on a rising edge where valid & ready are both
// high. The whole pipeline moves on one advance signal,
// adv = !out_valid | out_ready, which is also in_ready; when adv is low every
// stage (tree levels, sideband, accumulators, output register) holds, so no
// beat or result is lost or duplicated. in_ready never depends on in_valid.
// ---------------------------------------------------------------------------
module psum_accum_tree
   import psum_pkg::*;
#(
   parameter int PROD_W = PROD_W_DEF,
   parameter int KMAX   = KMAX_DEF,
   parameter int N_OUT  = N_OUT_DEF,
   parameter int PSUM_W = PSUM_W_DEF
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic [$clog2(KMAX+1)-1:0]    cfg_ksize,
   input  logic                         cfg_stride2,
   input  logic                         in_valid,
   output logic                         in_ready,
   input  logic                         in_first,
   input  logic                         in_last,
   input  logic [N_OUT*KMAX*PROD_W-1:0] in_prod,
   output logic                         out_valid,
   input  logic                         out_ready,
   output logic [N_OUT*PSUM_W-1:0]      out_psum,
   output logic [N_OUT-1:0]             out_sat
);

   localparam int TD   = $clog2(KMAX);
   localparam int KW   = $clog2(KMAX + 1);
   localparam int HALF = N_OUT / 2;

   logic adv;

   // Sideband pipeline, index TD-1 is aligned with the tree output.
   logic [TD-1:0] vld_q, vld_d;
   logic [TD-1:0] first_q, first_d;
   logic [TD-1:0] last_q, last_d;
   logic [TD-1:0] str_q, str_d;

   logic signed [PSUM_W-1:0] tree_sum [N_OUT];

   logic signed [PSUM_W-1:0] acc_q [N_OUT];
   logic signed [PSUM_W-1:0] acc_d [N_OUT];
   logic [N_OUT-1:0]         flag_q, flag_d;

   logic                     out_valid_q, out_valid_d;
   logic signed [PSUM_W-1:0] psum_q [N_OUT];
   logic signed [PSUM_W-1:0] psum_d [N_OUT];
   logic [N_OUT-1:0]         sat_q, sat_d;

   // Per-lane value and sticky flag this beat would produce.
   logic [SAT_IW:0]          sa     [N_OUT];
   logic signed [PSUM_W-1:0] s_lane [N_OUT];
   logic [N_OUT-1:0]         s_flag;

   assign adv       = !out_valid_q || out_ready;
   assign in_ready  = adv;
   assign out_valid = out_valid_q;
   assign out_sat   = sat_q;

   for (genvar l = 0; l < N_OUT; l++) begin : g_lane
      psum_tree_lane #(
         .PROD_W (PROD_W),
         .KMAX   (KMAX),
         .PSUM_W (PSUM_W),
         .TD     (TD),
         .KW     (KW)
      ) u_lane (
         .clk   (clk),
         .rst   (rst),
         .en    (adv),
         .ksize (cfg_ksize),
         .prod  (in_prod[l*KMAX*PROD_W +: KMAX*PROD_W]),
         .sum   (tree_sum[l])
      );
      assign out_psum[l*PSUM_W +: PSUM_W] = psum_q[l];
   end

   // Sideband shift register; ksize is consumed by the lane masks on entry,
   // stride2/first/last ride along to the accumulate stage.
   always_comb begin
      vld_d   = vld_q;
      first_d = first_q;
      last_d  = last_q;
      str_d   = str_q;
      if (adv) begin
         vld_d[0]   = in_valid;
         first_d[0] = in_first;
         last_d[0]  = in_last;
         str_d[0]   = cfg_stride2;
         for (int i = 1; i < TD; i++) begin
            vld_d[i]   = vld_q[i-1];
            first_d[i] = first_q[i-1];
            last_d[i]  = last_q[i-1];
            str_d[i]   = str_q[i-1];
         end
      end
   end

   // A first beat restarts from the raw tree sum, which always fits PSUM_W,
   // so it can never saturate and clears the sticky flag.
   always_comb begin
      s_flag = '0;
      for (int l = 0; l < N_OUT; l++) begin
         sa[l] = sat_add(SAT_IW'(acc_q[l]), SAT_IW'(tree_sum[l]), PSUM_W);
         if (first_q[TD-1]) begin
            s_lane[l] = tree_sum[l];
            s_flag[l] = 1'b0;
         end else begin
            s_lane[l] = PSUM_W'(sa[l][SAT_IW-1:0]);
            s_flag[l] = flag_q[l] | sa[l][SAT_IW];
         end
      end
   end

   always_comb begin
      acc_d       = acc_q;
      flag_d      = flag_q;
      out_valid_d = out_valid_q;
      psum_d      = psum_q;
      sat_d       = sat_q;
      if (adv) begin
         // adv high means the current result (if any) is being taken now.
         out_valid_d = 1'b0;
         if (vld_q[TD-1]) begin
            if (last_q[TD-1]) begin
               out_valid_d = 1'b1;
               flag_d      = '0;
               for (int l = 0; l < N_OUT; l++) begin
                  acc_d[l] = '0;
               end
               if (str_q[TD-1]) begin
                  sat_d = '0;
                  for (int i = 0; i < HALF; i++) begin
                     psum_d[i] = s_lane[2*i];
                     sat_d[i]  = s_flag[2*i];
                  end
                  for (int i = HALF; i < N_OUT; i++) begin
                     psum_d[i] = '0;
                  end
               end else begin
                  psum_d = s_lane;
                  sat_d  = s_flag;
               end
            end else begin
               acc_d  = s_lane;
               flag_d = s_flag;
            end
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         vld_q       <= '0;
         first_q     <= '0;
         last_q      <= '0;
         str_q       <= '0;
         flag_q      <= '0;
         out_valid_q <= 1'b0;
         sat_q       <= '0;
         for (int l = 0; l < N_OUT; l++) begin
            acc_q[l]  <= '0;
            psum_q[l] <= '0;
         end
      end else begin
         vld_q       <= vld_d;
         first_q     <= first_d;
         last_q      <= last_d;
         str_q       <= str_d;
         flag_q      <= flag_d;
         out_valid_q <= out_valid_d;
         sat_q       <= sat_d;
         acc_q       <= acc_d;
         psum_q      <= psum_d;
      end
   end

endmodule

// File: tb/tb_psum_accum_tree.sv
module tb_psum_accum_tree;

   localparam int PROD_W = 16;
   localparam int KMAX   = 9;
   localparam int N_OUT  = 8;
   localparam int PSUM_W = 24;
   localparam int KSZ_W  = 4;
   localparam int PW     = N_OUT * KMAX * PROD_W;
   localparam int EW     = N_OUT + N_OUT * PSUM_W;
   localparam int LAT    = 5;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   logic [KSZ_W-1:0]        cfg_ksize;
   logic                    cfg_stride2;
   logic                    in_valid;
   logic                    in_ready;
   logic                    in_first;
   logic                    in_last;
   logic [PW-1:0]           in_prod;
   logic                    out_valid;
   logic                    out_ready;
   logic [N_OUT*PSUM_W-1:0] out_psum;
   logic [N_OUT-1:0]        out_sat;

   psum_accum_tree #(
      .PROD_W (PROD_W),
      .KMAX   (KMAX),
      .N_OUT  (N_OUT),
      .PSUM_W (PSUM_W)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .cfg_ksize   (cfg_ksize),
      .cfg_stride2 (cfg_stride2),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .in_first    (in_first),
      .in_last     (in_last),
      .in_prod     (in_prod),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .out_psum    (out_psum),
      .out_sat     (out_sat)
   );

   // ---------------- scoreboard state ----------------
   logic [EW-1:0] exp_q[$];
   int n_checks = 0;
   int n_fail   = 0;
   int n_out    = 0;
   logic bp_on  = 1'b0;

   task automatic check_eq(input string tag, input logic [EW-1:0] got, input logic [EW-1:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // ---------------- stimulus helpers ----------------
   function automatic logic [PW-1:0] taps_uni(input int v);
      logic [PW-1:0] p;
      for (int i = 0; i < N_OUT * KMAX; i++) p[i*PROD_W +: PROD_W] = PROD_W'(v);
      return p;
   endfunction

   // Lane l carries value l+1 on every tap.
   function automatic logic [PW-1:0] taps_by_lane();
      logic [PW-1:0] p;
      for (int l = 0; l < N_OUT; l++)
         for (int t = 0; t < KMAX; t++) p[(l*KMAX+t)*PROD_W +: PROD_W] = PROD_W'(l + 1);
      return p;
   endfunction

   function automatic logic [EW-1:0] exp_uni(input int v, input logic s);
      logic [EW-1:0] e;
      for (int l = 0; l < N_OUT; l++) begin
         e[l*PSUM_W +: PSUM_W]   = PSUM_W'(v);
         e[N_OUT*PSUM_W + l]     = s;
      end
      return e;
   endfunction

   function automatic logic [EW-1:0] exp_lanes(input int v[N_OUT]);
      logic [EW-1:0] e;
      e = '0;
      for (int l = 0; l < N_OUT; l++) e[l*PSUM_W +: PSUM_W] = PSUM_W'(v[l]);
      return e;
   endfunction

   // ---------------- driver tasks ----------------
   task automatic send(input logic f, input logic l, input int ks, input logic s2,
                       input logic [PW-1:0] p);
      logic acc;
      acc = 1'b0;
      @(negedge clk);
      in_valid    = 1'b1;
      in_first    = f;
      in_last     = l;
      cfg_ksize   = KSZ_W'(ks);
      cfg_stride2 = s2;
      in_prod     = p;
      for (int g = 0; g < 200 && !acc; g++) begin
         #1;
         acc = in_ready;
         @(posedge clk);
         if (!acc) @(negedge clk);
      end
      check_eq("beat_accept", EW'(acc), EW'(1));
   endtask

   task automatic idle();
      @(negedge clk);
      in_valid = 1'b0;
      in_first = 1'b0;
      in_last  = 1'b0;
   endtask

   task automatic drain(input int max_cyc);
      for (int i = 0; i < max_cyc && exp_q.size() != 0; i++) @(posedge clk);
      check_eq("drain_empty", EW'(exp_q.size()), EW'(0));
   endtask

   // out_ready: steady 1, or 1010.. while backpressure is on
   initial begin
      out_ready = 1'b1;
      forever begin
         @(negedge clk);
         out_ready = bp_on ? ~out_ready : 1'b1;
      end
   end

   // ---------------- monitor / scoreboard ----------------
   initial begin
      logic [EW-1:0] e;
      forever begin
         @(negedge clk);
         #2;
         if (!rst) begin
            check_eq("in_ready_rule", EW'(in_ready), EW'(!(out_valid && !out_ready)));
            if (out_valid && out_ready) begin
               n_out++;
               check_eq("exp_available", EW'(exp_q.size() > 0), EW'(1));
               if (exp_q.size() > 0) begin
                  e = exp_q.pop_front();
                  check_eq("out_result", {out_sat, out_psum}, e);
               end
            end
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog expired");
      $fatal(1, "timeout");
   end

   // ---------------- directed tests ----------------
   initial begin
      int lat;
      int n0;
      int stride_exp[N_OUT] = '{1, 3, 5, 7, 0, 0, 0, 0};

      rst = 1'b1; in_valid = 1'b0; in_first = 1'b0; in_last = 1'b0;
      cfg_ksize = '0; cfg_stride2 = 1'b0; in_prod = '0;
      repeat (3) @(negedge clk);
      check_eq("rst_out_valid", EW'(out_valid), EW'(0));
      check_eq("rst_in_ready", EW'(in_ready), EW'(1));
      check_eq("rst_psum_sat", {out_sat, out_psum}, EW'(0));
      rst = 1'b0;

      // 1: reset mid-stream; acc holds 63 and two results are in flight
      send(1'b1, 1'b0, 9, 1'b0, taps_uni(7));
      idle();
      repeat (8) @(negedge clk);
      send(1'b1, 1'b1, 9, 1'b0, taps_uni(3));
      send(1'b1, 1'b1, 9, 1'b0, taps_uni(4));
      #3;
      rst = 1'b1; in_valid = 1'b0; in_first = 1'b0; in_last = 1'b0;
      #20;
      check_eq("midrst_out_valid", EW'(out_valid), EW'(0));
      check_eq("midrst_in_ready", EW'(in_ready), EW'(1));
      check_eq("midrst_psum_sat", {out_sat, out_psum}, EW'(0));
      @(negedge clk);
      rst = 1'b0;
      n0 = n_out;
      repeat (10) @(negedge clk);
      check_eq("midrst_no_spurious", EW'(n_out), EW'(n0));
      // last without first: accumulates onto a cleared acc
      exp_q.push_back(exp_uni(18, 1'b0));
      send(1'b0, 1'b1, 9, 1'b0, taps_uni(2));
      idle();
      drain(50);

      // 2: single-round windows, latency and masking
      exp_q.push_back(exp_uni(27, 1'b0));
      send(1'b1, 1'b1, 9, 1'b0, taps_uni(3));
      @(negedge clk);
      in_valid = 1'b0; in_first = 1'b0; in_last = 1'b0;
      lat = 1;
      while (!out_valid && lat < 20) begin
         @(negedge clk);
         lat++;
      end
      check_eq("latency", EW'(lat), EW'(LAT));
      drain(50);
      exp_q.push_back(exp_uni(12, 1'b0));
      exp_q.push_back(exp_uni(0, 1'b0));
      exp_q.push_back(exp_uni(27, 1'b0));
      send(1'b1, 1'b1, 4, 1'b0, taps_uni(3));
      send(1'b1, 1'b1, 0, 1'b0, taps_uni(3));
      send(1'b1, 1'b1, 15, 1'b0, taps_uni(3));
      idle();
      drain(50);

      // 3: three rounds, exactly one result
      n0 = n_out;
      exp_q.push_back(exp_uni(-54, 1'b0));
      send(1'b1, 1'b0, 9, 1'b0, taps_uni(-2));
      send(1'b0, 1'b0, 9, 1'b0, taps_uni(-2));
      send(1'b0, 1'b1, 9, 1'b0, taps_uni(-2));
      idle();
      drain(50);
      repeat (10) @(negedge clk);
      check_eq("three_round_count", EW'(n_out - n0), EW'(1));
      // first mid-accumulation discards the earlier 45
      exp_q.push_back(exp_uni(9, 1'b0));
      send(1'b1, 1'b0, 9, 1'b0, taps_uni(5));
      send(1'b1, 1'b1, 9, 1'b0, taps_uni(1));
      idle();
      drain(50);

      // 4: saturation over 40 rounds, then a fresh window clears it
      exp_q.push_back(exp_uni(8388607, 1'b1));
      for (int r = 0; r < 40; r++) send(r == 0, r == 39, 9, 1'b0, taps_uni(32767));
      idle();
      drain(80);
      exp_q.push_back(exp_uni(9, 1'b0));
      send(1'b1, 1'b1, 9, 1'b0, taps_uni(1));
      idle();
      drain(50);

      // 5: stride-2 compaction
      exp_q.push_back(exp_lanes(stride_exp));
      send(1'b1, 1'b1, 1, 1'b1, taps_by_lane());
      idle();
      drain(50);

      // 6: backpressure with out_ready toggling, including a 2-round window
      bp_on = 1'b1;
      for (int k = 0; k < 10; k++) begin
         exp_q.push_back(exp_uni(9 * (k + 1), 1'b0));
         send(1'b1, 1'b1, 9, 1'b0, taps_uni(k + 1));
         if (k == 4) begin
            exp_q.push_back(exp_uni(27, 1'b0));
            send(1'b1, 1'b0, 9, 1'b0, taps_uni(1));
            send(1'b0, 1'b1, 9, 1'b0, taps_uni(2));
         end
      end
      idle();
      drain(300);
      bp_on = 1'b0;
      repeat (10) @(negedge clk);
      check_eq("final_out_valid", EW'(out_valid), EW'(0));

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
